// File: rtl/wb_req_master.sv
// Wishbone pipelined master: one valid/ready request becomes one Wishbone cycle,
// with rty retries, a cycle timeout and a single response pulse per request.
module wb_req_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [31:0]           req_dat_i,
  input  logic [3:0]            req_sel_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STROBE  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_BACKOFF = 2'd3;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  logic [1:0]  state;
  logic [15:0] tmo_cnt;
  logic [3:0]  retry_cnt;

  logic active;
  logic done;
  logic fail;
  logic tmo_hit;
  logic retry_go;

  assign active = (state == S_STROBE) || (state == S_WAIT);

  // Termination resolution: err > ack > rty, and any termination beats the timeout.
  always_comb begin
    done     = 1'b0;
    fail     = 1'b0;
    tmo_hit  = 1'b0;
    retry_go = 1'b0;
    if (active) begin
      if (wb_err_i) begin
        done = 1'b1;
        fail = 1'b1;
      end else if (wb_ack_i) begin
        done = 1'b1;
      end else if (wb_rty_i) begin
        if (retry_cnt == RETRY_MAX) begin
          done = 1'b1;
          fail = 1'b1;
        end else begin
          retry_go = 1'b1;
        end
      end else if (tmo_cnt == TMO_LAST) begin
        done    = 1'b1;
        fail    = 1'b1;
        tmo_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      req_ready_o   <= 1'b1;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_sel_o      <= '0;
      wb_dat_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      retry_cnt     <= '0;
      tmo_cnt       <= '0;
    end else begin
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            wb_we_o     <= req_we_i;
            wb_adr_o    <= req_adr_i;
            wb_dat_o    <= req_dat_i;
            wb_sel_o    <= req_sel_i;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            req_ready_o <= 1'b0;
            state       <= S_STROBE;
          end
        end
        S_STROBE, S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (done) begin
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= fail;
            rsp_timeout_o <= tmo_hit;
            if (!fail && !wb_we_o) rsp_dat_o <= wb_dat_i;
            state         <= S_IDLE;
          end else if (retry_go) begin
            retry_cnt <= retry_cnt + 4'd1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= S_BACKOFF;
          end else if (state == S_STROBE && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= S_WAIT;
          end
        end
        default: begin
          // BACKOFF: one idle-bus cycle, then re-issue the strobe with a fresh timeout.
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          tmo_cnt  <= '0;
          state    <= S_STROBE;
        end
      endcase
    end
  end

endmodule
